// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the MIPS ID/EX slice.
// ALU opcodes, forward-select encoding and the bubble control bundle.
package pipe_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_NOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1000;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [3:0] alu_ctl;
        logic       shift_c;
        logic       alu_src;
    } ex_ctl_t;

    localparam ex_ctl_t BUBBLE_CTL = '0;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding for one source index: EX/MEM beats MEM/WB, $0 never forwards.
// Ports: i_idx/i_reg_data (EX-slot source), EX/MEM and MEM/WB writers, o_sel/o_data.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_idx,
    input  logic [DATA_W-1:0] i_reg_data,
    input  logic              i_exmem_we,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_data,
    input  logic              i_memwb_we,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_data,
    output fwd_sel_e          o_sel,
    output logic [DATA_W-1:0] o_data
);

    logic w_ex_hit;
    logic w_wb_hit;

    assign w_ex_hit = i_exmem_we & (|i_exmem_rd) & (i_exmem_rd == i_idx);
    assign w_wb_hit = i_memwb_we & (|i_memwb_rd) & (i_memwb_rd == i_idx);

    always_comb begin
        o_sel = FWD_REG;
        if (w_ex_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

    always_comb begin
        o_data = i_reg_data;
        case (o_sel)
            FWD_EXMEM: o_data = i_exmem_data;
            FWD_MEMWB: o_data = i_memwb_data;
            default:   o_data = i_reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches ID, forwards operands, detects load-use.
// Inputs id_* / exmem_* / memwb_* / ex_hold / ex_flush; outputs alu_*, ex_*, lu_stall, stall_count.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [3:0]        id_alu_ctl,
    input  logic              id_shift_c,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_alu_out,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_wdata,
    input  logic              ex_hold,
    input  logic              ex_flush,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctl,
    output logic              alu_shift_c,
    output logic [4:0]        alu_shift_v,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_wr_reg,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              lu_stall,
    output logic [CNT_W-1:0]  stall_count
);

    logic              r_valid;
    ex_ctl_t           r_ctl;
    logic [REG_AW-1:0] r_wr_reg;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_shamt;
    logic [CNT_W-1:0]  r_stall_count;

    ex_ctl_t           w_id_ctl;
    logic              w_rs_hit;
    logic              w_rt_hit;
    logic              w_lu_stall;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;
    fwd_sel_e          w_rs_sel;
    fwd_sel_e          w_rt_sel;
    logic              w_unused;

    assign w_id_ctl = '{
        reg_write:  id_reg_write,
        mem_read:   id_mem_read,
        mem_write:  id_mem_write,
        mem_to_reg: id_mem_to_reg,
        alu_ctl:    id_alu_ctl,
        shift_c:    id_shift_c,
        alu_src:    id_alu_src
    };

    // A load in EX cannot feed ID next cycle; $0 destinations never hazard.
    assign w_rs_hit   = id_uses_rs & (id_rs == r_wr_reg);
    assign w_rt_hit   = id_uses_rt & (id_rt == r_wr_reg);
    assign w_lu_stall = id_valid & r_valid & r_ctl.mem_read
                      & (|r_wr_reg) & (w_rs_hit | w_rt_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_ctl         <= BUBBLE_CTL;
            r_wr_reg      <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
            r_shamt       <= '0;
            r_stall_count <= '0;
        end else if (!ex_hold) begin
            // Flush, load-use and an empty ID slot all load a zeroed bubble.
            if (ex_flush || w_lu_stall || !id_valid) begin
                r_valid   <= 1'b0;
                r_ctl     <= BUBBLE_CTL;
                r_wr_reg  <= '0;
                r_rs      <= '0;
                r_rt      <= '0;
                r_rs_data <= '0;
                r_rt_data <= '0;
                r_imm     <= '0;
                r_shamt   <= '0;
            end else begin
                r_valid   <= 1'b1;
                r_ctl     <= w_id_ctl;
                r_wr_reg  <= id_wr_reg;
                r_rs      <= id_rs;
                r_rt      <= id_rt;
                r_rs_data <= id_rs_data;
                r_rt_data <= id_rt_data;
                r_imm     <= id_imm;
                r_shamt   <= id_shamt;
            end
            if (!ex_flush && w_lu_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    fwd_unit #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .i_idx        (r_rs),
        .i_reg_data   (r_rs_data),
        .i_exmem_we   (exmem_reg_write),
        .i_exmem_rd   (exmem_rd),
        .i_exmem_data (exmem_alu_out),
        .i_memwb_we   (memwb_reg_write),
        .i_memwb_rd   (memwb_rd),
        .i_memwb_data (memwb_wdata),
        .o_sel        (w_rs_sel),
        .o_data       (w_fwd_rs)
    );

    fwd_unit #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .i_idx        (r_rt),
        .i_reg_data   (r_rt_data),
        .i_exmem_we   (exmem_reg_write),
        .i_exmem_rd   (exmem_rd),
        .i_exmem_data (exmem_alu_out),
        .i_memwb_we   (memwb_reg_write),
        .i_memwb_rd   (memwb_rd),
        .i_memwb_data (memwb_wdata),
        .o_sel        (w_rt_sel),
        .o_data       (w_fwd_rt)
    );

    // Selects are kept for debug visibility only.
    assign w_unused = ^{w_rs_sel, w_rt_sel};

    // Constant shifts take the shifted value from rt, not the immediate.
    assign alu_a         = w_fwd_rs;
    assign alu_b         = (!r_ctl.alu_src || r_ctl.shift_c) ? w_fwd_rt : r_imm;
    assign alu_ctl       = r_ctl.alu_ctl;
    assign alu_shift_c   = r_ctl.shift_c;
    assign alu_shift_v   = r_shamt;
    assign ex_valid      = r_valid;
    assign ex_wr_reg     = r_wr_reg;
    assign ex_store_data = w_fwd_rt;
    assign ex_reg_write  = r_ctl.reg_write;
    assign ex_mem_read   = r_ctl.mem_read;
    assign ex_mem_write  = r_ctl.mem_write;
    assign ex_mem_to_reg = r_ctl.mem_to_reg;
    assign lu_stall      = w_lu_stall;
    assign stall_count   = r_stall_count;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-delivery stage for the 5-stage MIPS pipeline.
- Latches decoded instructions from ID and resolves EX/MEM and MEM/WB forwarding.
- Drives the EX-stage ALU inputs (A, B, ALUctl, shiftC, shiftV).
- Detects load-use hazards, inserts bubbles, and counts stall events.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-index width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_wr_reg  in  REG_AW  source indices and destination index (already rd/rt-selected).
- id_uses_rs, id_uses_rt  in  1  instruction reads rs / rt.
- id_rs_data, id_rt_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign/zero-extended immediate.
- id_shamt  in  5  shift amount.
- id_alu_ctl  in  4  ALU opcode.
- id_shift_c  in  1  constant-shift select.
- id_alu_src  in  1  1 = B from immediate.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  downstream controls.
- exmem_reg_write  in  1  EX/MEM instruction writes a register.
- exmem_rd  in  REG_AW  EX/MEM destination index.
- exmem_alu_out  in  DATA_W  EX/MEM result.
- memwb_reg_write  in  1  MEM/WB instruction writes a register.
- memwb_rd  in  REG_AW  MEM/WB destination index.
- memwb_wdata  in  DATA_W  MEM/WB write-back data.
- ex_hold  in  1  downstream freeze.
- ex_flush  in  1  kill the instruction entering EX.
- alu_a, alu_b  out  DATA_W  ALU operands.
- alu_ctl  out  4  ALU opcode.
- alu_shift_c  out  1  constant-shift select.
- alu_shift_v  out  5  shift amount.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_wr_reg  out  REG_AW  destination index.
- ex_store_data  out  DATA_W  forwarded rt value for stores.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered controls.
- lu_stall  out  1  load-use stall; IF/ID must hold.
- stall_count  out  CNT_W  saturating count of bubble cycles.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All EX registers and outputs go to 0, including ex_valid, controls, alu_ctl, shamt and stall_count.
  - lu_stall is 0 because ex_valid is 0.
  - Releasing reset mid-stream gives an empty EX slot on the next edge.
- Registers update only on the rising clk edge. Priority per edge:
  - ex_hold: all EX registers keep their value, stall_count unchanged, lu_stall still computed combinationally.
  - else ex_flush: load a bubble.
  - else lu_stall: load a bubble and increment stall_count.
  - else: load the ID fields, with ex_valid <= id_valid.
- Bubble contents: ex_valid = 0; reg_write, mem_read, mem_write, mem_to_reg = 0; alu_ctl = 0; shift_c = 0; wr_reg = 0; data fields don't-care (driven 0).
- id_valid = 0 loads the same zeroed controls as a bubble.
- ex_flush asserted during ex_hold is ignored. The flush source keeps it asserted until ex_hold drops.
- lu_stall (combinational) = id_valid & ex_valid & ex_mem_read & (ex_wr_reg != 0) & ((id_uses_rs & id_rs == ex_wr_reg) | (id_uses_rt & id_rt == ex_wr_reg)).
  - Exactly one bubble per load-use; the stall clears next cycle because the load has left EX.
- Forwarding is combinational, on the registered rs/rt of the EX slot, separately for rs and rt:
  - If exmem_reg_write & exmem_rd != 0 & exmem_rd == idx: use exmem_alu_out.
  - else if memwb_reg_write & memwb_rd != 0 & memwb_rd == idx: use memwb_wdata.
  - else use the registered register-file data.
  - Register 0 is never forwarded. EX/MEM wins over MEM/WB for the same index.
  - No forwarding from a load in EX/MEM; the load-use stall makes that case unreachable.
- Operand muxing:
  - alu_a = fwd_rs.
  - alu_b = fwd_rt when alu_src = 0 or shift_c = 1; otherwise the registered imm.
  - alu_shift_v = registered shamt. ex_store_data = fwd_rt.
- Latency: one cycle from ID inputs to EX outputs; forwarding adds zero cycles.
- stall_count saturates at all-ones; it never wraps.

Decomposition:
- Shared package pipe_pkg:
  - ALU opcode constants (ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_NOR = 4'b0011, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_XOR = 4'b1000).
  - Forward-select enum FWD_REG / FWD_EXMEM / FWD_MEMWB.
  - Bubble control-bundle constant.
- One sub-module: fwd_unit (combinational index compare and 3-way select, outputs the select and the data), instantiated twice for rs and rt.

Test Plan:
- Reset mid-stream:
  - Stimulus: pulse rst_n low asynchronously between edges while ex_valid = 1 and stall_count = 5.
  - Response: ex_valid, alu_ctl, ex_reg_write and stall_count read 0 immediately, before the next edge.
- EX/MEM forwarding:
  - Stimulus: add with id_rs = 8, rt = 9, rs_data = 1, rt_data = 2; next cycle exmem_reg_write = 1, exmem_rd = 8, exmem_alu_out = 0x64.
  - Response: alu_a = 0x64, alu_b = 2.
- Double hazard and $0:
  - Stimulus: exmem_rd = memwb_rd = 9 with values 0xAA / 0xBB.
  - Response: alu_b = 0xAA.
  - Stimulus: same with index 0.
  - Response: register-file value used.
- Load-use:
  - Stimulus: lw with wr_reg 10 in EX, ID uses rs = 10.
  - Response: lu_stall = 1 for one cycle, bubble in EX (ex_valid = 0, ex_reg_write = 0), stall_count 0 -> 1; the dependent instruction enters EX next cycle.
- Hold versus flush:
  - Stimulus: ex_hold = 1 and ex_flush = 1 together for 3 cycles.
  - Response: EX contents unchanged.
  - Stimulus: hold drops with flush still 1.
  - Response: bubble loaded.
- Immediate and shift selection:
  - Stimulus: alu_src = 1, imm = 0xFFFFFFFC.
  - Response: alu_b = 0xFFFFFFFC.
  - Stimulus: shift_c = 1, shamt = 4, alu_src = 1.
  - Response: alu_b = fwd_rt, alu_shift_v = 4.
  - Stimulus: 2^16 + 3 stalls.
  - Response: stall_count = 0xFFFF.
